// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop sync + stability FSM -> debounced level, press strobe, updown toggle.
// Latency: press strobe/level rise DEBOUNCE_CYCLES+2 edges after btn_n falls; level falls DEBOUNCE_CYCLES+2 edges after btn_n rises.
// Backpressure: none; free-running, all outputs registered. Optional auto-repeat enabled by defining BUTTON_REPEAT_EN.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic ck,
    input  logic reset,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic updown
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic          r_s1;
    logic          r_s2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_updown;
    logic          w_rep_pulse;
    logic          w_held;

    // Button is considered held while pressed or bouncing on the way out.
    assign w_held = (r_state == PRESSED) || (r_state == WAIT_RELEASE);

    // Two-flop synchronizer; released (1) is the safe reset value.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= btn_n;
            r_s2 <= r_s1;
        end
    end

    // Stability FSM: a level change is accepted only after the counter sees it stable.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_press  <= 1'b0;
            r_updown <= 1'b1;
        end else begin
            r_press <= w_rep_pulse;
            case (r_state)
                IDLE: begin
                    if (!r_s2) begin
                        r_state <= WAIT_PRESS;
                        r_cnt   <= CW'(1);
                    end
                end
                WAIT_PRESS: begin
                    if (r_s2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state  <= PRESSED;
                        r_cnt    <= '0;
                        r_level  <= 1'b1;
                        r_press  <= 1'b1;
                        r_updown <= ~r_updown;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (r_s2) begin
                        r_state <= WAIT_RELEASE;
                        r_cnt   <= CW'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (!r_s2) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] r_hold_cnt;
    logic          r_repeating;
    logic          w_rep_hit;

    // First hit waits HOLD_CYCLES after entry, later hits every REPEAT_CYCLES.
    assign w_rep_hit   = w_held && (r_hold_cnt == (r_repeating ? REP_LAST : HOLD_LAST));
    assign w_rep_pulse = w_rep_hit;

    // Hold timer runs through release bounces and restarts on every new press.
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end else if (w_held) begin
            if (w_rep_hit) begin
                r_hold_cnt  <= '0;
                r_repeating <= 1'b1;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end else begin
            r_hold_cnt  <= '0;
            r_repeating <= 1'b0;
        end
    end
`else
    // No auto-repeat: hold/repeat parameters only appear in this constant-false term.
    assign w_rep_pulse = (HOLD_CYCLES < 0) && (REPEAT_CYCLES < 0) && w_held;
`endif

    assign btn_level = r_level;
    assign btn_press = r_press;
    assign updown    = r_updown;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random key activity.
// Reference model tracks run lengths of the synchronized key against the accepted level.
// Outputs are compared on the falling edge after every rising edge.
module tb_button_debouncer;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic ck = 1'b0;
    logic reset;
    logic btn_n;
    logic btn_level;
    logic btn_press;
    logic updown;

    int n_chk = 0;
    int n_err = 0;
    int obs_pulses = 0;

    // model state
    logic m_s1, m_s2, m_level, m_press, m_updown;
    int   m_run, m_k;

    always #5 ck = ~ck;

    button_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .ck       (ck),
        .reset    (reset),
        .btn_n    (btn_n),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .updown   (updown)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_press = 1'b0;
        m_updown = 1'b1; m_run = 0; m_k = 0;
    endtask

    // One rising edge: a level flips once the synchronized key disagrees with it for D+1 samples.
    task automatic model_edge(input logic b);
        m_press = 1'b0;
`ifdef BUTTON_REPEAT_EN
        if (m_level) begin
            m_k = m_k + 1;
            if (m_k >= H && ((m_k - H) % R) == 0) m_press = 1'b1;
        end
`endif
        if ((!m_s2) != m_level) m_run = m_run + 1;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_level = !m_level;
            m_run = 0;
            if (m_level) begin
                m_press  = 1'b1;
                m_updown = !m_updown;
                m_k      = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".level"},  int'(btn_level), int'(m_level));
        chk({tag, ".press"},  int'(btn_press), int'(m_press));
        chk({tag, ".updown"}, int'(updown),    int'(m_updown));
    endtask

    // Drive key on the falling edge, let one rising edge happen, compare on next falling edge.
    task automatic step(input logic b, input string tag);
        btn_n = b;
        @(posedge ck);
        model_edge(b);
        @(negedge ck);
        check_outputs(tag);
        if (btn_press) obs_pulses++;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input int ncyc, input string tag);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        repeat (ncyc) @(negedge ck);
        reset = 1'b1;
    endtask

    initial begin
        int p0;
        int exp_rep;
        reset = 1'b1;
        btn_n = 1'b1;
        model_reset();
        @(negedge ck);

        // reset held 3 cycles, then idle with key released
        do_reset(3, "rst");
        for (int i = 0; i < 6; i++) step(1'b1, "rst_idle");
        chk("rst_idle_pulses", obs_pulses, 0);

        // clean press held 20, then release 20
        obs_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, "clean_press");
            if (i == 6) begin
                chk("clean_press_pulse_e6", int'(btn_press), 1);
                chk("clean_press_updown_e6", int'(updown), 0);
            end
        end
        chk("clean_press_pulses", obs_pulses, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, "clean_release");
            if (i == 5) chk("clean_rel_level_e5", int'(btn_level), 1);
            if (i == 6) chk("clean_rel_level_e6", int'(btn_level), 0);
        end
        chk("clean_release_pulses", obs_pulses, 1);

        // bounce every 2 cycles for 16 cycles, then hold low
        obs_pulses = 0;
        for (int i = 0; i < 16; i++) step(((i / 2) % 2) ? 1'b1 : 1'b0, "bounce");
        chk("bounce_no_pulse", obs_pulses, 0);
        for (int i = 0; i < 14; i++) step(1'b0, "bounce_hold");
        chk("bounce_one_pulse", obs_pulses, 1);
        for (int i = 0; i < 10; i++) step(1'b1, "bounce_rel");

        // direction toggle over three presses (fresh reset so updown starts at 1)
        do_reset(2, "rst_dir");
        @(negedge ck);
        obs_pulses = 0;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 12; i++) step(1'b0, "dir_press");
            chk("dir_updown", int'(updown), (n % 2 == 0) ? 0 : 1);
            for (int i = 0; i < 12; i++) step(1'b1, "dir_release");
        end
        chk("dir_pulses", obs_pulses, 3);

        // reset while in WAIT_PRESS with counter at 2, key kept low
        for (int i = 0; i < 4; i++) step(1'b0, "midrst_pre");
        btn_n = 1'b0;
        do_reset(2, "midrst");
        obs_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, "midrst_post");
            if (i == 6) chk("midrst_pulse_e6", int'(btn_press), 1);
        end
        chk("midrst_pulses", obs_pulses, 1);
        chk("midrst_updown", int'(updown), 0);
        for (int i = 0; i < 10; i++) step(1'b1, "midrst_rel");

        // long hold: auto-repeat when enabled, single pulse otherwise
        obs_pulses = 0;
        for (int i = 0; i < 50; i++) step(1'b0, "hold");
        for (int i = 0; i < 12; i++) step(1'b1, "hold_rel");
`ifdef BUTTON_REPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        chk("hold_pulses", obs_pulses, exp_rep);

        // random key activity with occasional resets
        for (int n = 0; n < 300; n++) begin
            logic b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) begin
                btn_n = b;
                do_reset($urandom_range(1, 3), "rnd_rst");
            end
            p0 = obs_pulses;
            for (int i = 0; i < len; i++) step(b, "rnd");
            if (obs_pulses < p0) chk("rnd_pulse_count", obs_pulses, p0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw push-button from the FPGA board into clean control signals for the up/down counter stage. The raw input passes through a two-flop synchronizer and a stability-timing state machine. The block then produces a debounced level, a one-cycle press pulse, and a registered `updown` direction that toggles on each press. It sits directly upstream of the counter and drives its `updown` input. The press pulse is also available as a single-step strobe.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required before accepting a level change (10 ms at 50 MHz); must be ≥ 2.
- `HOLD_CYCLES`, default 25000000: pressed duration before auto-repeat starts. Used only when `BUTTON_REPEAT_EN` is defined.
- `REPEAT_CYCLES`, default 5000000: period between auto-repeat pulses. Used only when `BUTTON_REPEAT_EN` is defined.

Ports:
- `ck`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_n`  in  1  raw board key, asynchronous to `ck`; 0 = pressed.
- `btn_level`  out  1  debounced level; 1 = pressed.
- `btn_press`  out  1  one-cycle strobe on each accepted press, and on each auto-repeat when enabled.
- `updown`  out  1  count direction to the counter; 1 = up.

## Operation

- **Synchronizer:** two flops, `s1` and `s2`, both reset to 1 (released). Only `s2` feeds the state machine.
- **State machine states:** `IDLE`, `WAIT_PRESS`, `PRESSED`, `WAIT_RELEASE`. The reset state is `IDLE`.
- **Stability counter:** width is `$clog2(DEBOUNCE_CYCLES+1)`. It is cleared on every state change.
- **`IDLE`:**
  - `s2` = 0 → go to `WAIT_PRESS` with counter = 1.
  - Otherwise stay in `IDLE`.
- **`WAIT_PRESS`:**
  - `s2` = 1 → return to `IDLE`, clear the counter. No pulse, no toggle.
  - Counter = `DEBOUNCE_CYCLES` and `s2` = 0 → go to `PRESSED`.
  - Otherwise increment the counter.
- **Entering `PRESSED`:**
  - `btn_level` is set to 1.
  - `btn_press` is high for exactly that one cycle.
  - `updown` is inverted in the same cycle.
- **`PRESSED`:** `s2` = 1 → go to `WAIT_RELEASE` with counter = 1.
- **`WAIT_RELEASE`:**
  - `s2` = 0 → return to `PRESSED`. No pulse, no toggle.
  - Counter = `DEBOUNCE_CYCLES` and `s2` = 1 → go to `IDLE` and clear `btn_level`. No pulse on release.
  - Otherwise increment the counter.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` samples never changes `btn_level`, `btn_press` or `updown`.
- **Reset mid-operation:** reset in any state returns immediately to reset values. A button held through reset release is treated as a new press once it has been stable for `DEBOUNCE_CYCLES`.

## Timing

- **Reset values:** `btn_level` = 0, `btn_press` = 0, `updown` = 1, `s1` = `s2` = 1, counters = 0, state = `IDLE`.
- **Press latency:** `btn_n` falls and stays low, then `btn_press` is high during the cycle after the rising edge numbered `DEBOUNCE_CYCLES`+2, counting from the first edge at which `btn_n` is low. `btn_level` rises and `updown` toggles at that same edge.
- **Release latency:** `btn_level` falls `DEBOUNCE_CYCLES`+2 edges after `btn_n` rises and stays high.
- **Registered outputs:** all outputs are registered; there is no combinational path from `btn_n`.
- **Pulse spacing:** `btn_press` pulses are never adjacent. There are at least `DEBOUNCE_CYCLES` low cycles between any two pulses.

## Configuration

- **`BUTTON_REPEAT_EN` defined:**
  - A hold counter runs while in `PRESSED` and keeps running through a `WAIT_RELEASE` bounce.
  - After `HOLD_CYCLES` cycles in `PRESSED`, `btn_press` pulses once, then once every `REPEAT_CYCLES` cycles until the state machine leaves `PRESSED`/`WAIT_RELEASE` for `IDLE`.
  - Repeat pulses do not toggle `updown`; only the initial press toggles it.
- **`BUTTON_REPEAT_EN` undefined:**
  - Exactly one `btn_press` per accepted press.
  - The hold counter is not synthesized.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.

## Test plan

All scenarios use `DEBOUNCE_CYCLES` = 4, `HOLD_CYCLES` = 20, `REPEAT_CYCLES` = 8.

- **Reset:** hold `reset` = 0 for 3 cycles → `btn_level` = 0, `btn_press` = 0, `updown` = 1; no output change after release while `btn_n` = 1.
- **Clean press:** `btn_n` goes low at edge 0 and is held 20 cycles → single `btn_press` pulse after edge 6, `btn_level` = 1 and `updown` = 0 from that edge. Release and hold 20 cycles → `btn_level` = 0 six edges after `btn_n` rises, and no pulse occurs.
- **Bounce:** `btn_n` toggles low/high every 2 cycles for 16 cycles, then stays low → no pulse during the bounce; exactly one pulse 6 edges after the final fall.
- **Direction toggle:** three clean press/release cycles → `updown` sequence 1→0→1→0, with three pulses total.
- **Reset mid-press:** assert `reset` while in `WAIT_PRESS` (counter = 2) → all outputs return to reset values immediately. Keep `btn_n` low after reset release → pulse 6 edges later, and `updown` = 0.
- **Auto-repeat (`BUTTON_REPEAT_EN`):** hold the press for 50 cycles → initial pulse, then repeat pulses at 20, 28, 36 and 44 cycles after entering `PRESSED`. `updown` toggles only once. Without the macro, the same hold gives exactly one pulse.
